// File: rtl/uart_tx.sv
// UART transmitter: serializes one word per accepted tx_start, LSB first.
// Bit timing is derived from the 16x oversampling s_tick of the baud generator.
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int PAR_EN  = 0,
    parameter int PAR_ODD = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] din,
    output logic       tx_done_tick,
    output logic       tx_busy,
    output logic       tx
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    localparam logic [4:0] S_LAST  = 5'd15;
    localparam logic [4:0] SB_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] N_LAST  = 3'(DBIT - 1);
    localparam logic       P_INIT  = (PAR_ODD != 0);

    state_e     state_q;
    logic [4:0] s_q;
    logic [2:0] n_q;
    logic [7:0] b_q;
    logic       p_q;
    logic       tx_q;
    logic       done_q;
    logic       busy_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            s_q     <= '0;
            n_q     <= '0;
            b_q     <= '0;
            p_q     <= 1'b0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (tx_start) begin
                        b_q     <= din;
                        p_q     <= P_INIT;
                        s_q     <= '0;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= START;
                    end
                end
                START: begin
                    if (s_tick) begin
                        if (s_q == S_LAST) begin
                            s_q     <= '0;
                            n_q     <= '0;
                            tx_q    <= b_q[0];
                            state_q <= DATA;
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
                DATA: begin
                    if (s_tick) begin
                        if (s_q == S_LAST) begin
                            p_q <= p_q ^ b_q[0];
                            b_q <= b_q >> 1;
                            s_q <= '0;
                            if (n_q == N_LAST) begin
                                // b_q[0] is the last data bit, not yet folded into p_q
                                if (PAR_EN != 0) begin
                                    tx_q    <= p_q ^ b_q[0];
                                    state_q <= PARITY;
                                end else begin
                                    tx_q    <= 1'b1;
                                    state_q <= STOP;
                                end
                            end else begin
                                n_q  <= n_q + 3'd1;
                                tx_q <= b_q[1];
                            end
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
                PARITY: begin
                    if (s_tick) begin
                        if (s_q == S_LAST) begin
                            s_q     <= '0;
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
                STOP: begin
                    tx_q <= 1'b1;
                    if (s_tick) begin
                        if (s_q == SB_LAST) begin
                            s_q     <= '0;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end else begin
                            s_q <= s_q + 5'd1;
                        end
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign tx           = tx_q;
    assign tx_done_tick = done_q;
    assign tx_busy      = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five configurations share one stimulus stream and are
// compared every cycle against a tick-counting frame model.
module tb_uart_tx;

    localparam int NI = 5;
    localparam int CFG_DBIT [NI] = '{8, 8, 8, 7, 5};
    localparam int CFG_SB   [NI] = '{16, 16, 16, 32, 16};
    localparam int CFG_PE   [NI] = '{0, 1, 1, 0, 0};
    localparam int CFG_PO   [NI] = '{0, 0, 1, 0, 0};

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          s_tick = 1'b0;
    logic          tx_start = 1'b0;
    logic [7:0]    din = 8'h00;
    logic [NI-1:0] o_tx;
    logic [NI-1:0] o_busy;
    logic [NI-1:0] o_done;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx #(.DBIT(8), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) u8 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start),
        .din(din), .tx_done_tick(o_done[0]), .tx_busy(o_busy[0]), .tx(o_tx[0]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(0)) upe (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start),
        .din(din), .tx_done_tick(o_done[1]), .tx_busy(o_busy[1]), .tx(o_tx[1]));
    uart_tx #(.DBIT(8), .SB_TICK(16), .PAR_EN(1), .PAR_ODD(1)) upo (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start),
        .din(din), .tx_done_tick(o_done[2]), .tx_busy(o_busy[2]), .tx(o_tx[2]));
    uart_tx #(.DBIT(7), .SB_TICK(32), .PAR_EN(0), .PAR_ODD(0)) u7 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start),
        .din(din), .tx_done_tick(o_done[3]), .tx_busy(o_busy[3]), .tx(o_tx[3]));
    uart_tx #(.DBIT(5), .SB_TICK(16), .PAR_EN(0), .PAR_ODD(0)) u5 (
        .clk(clk), .reset_n(reset_n), .s_tick(s_tick), .tx_start(tx_start),
        .din(din), .tx_done_tick(o_done[4]), .tx_busy(o_busy[4]), .tx(o_tx[4]));

    function automatic void chk(input string nm, input logic [7:0] act,
                                input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference: a frame is a list of line levels, each 16 ticks long,
    // followed by SB ticks of stop; the level is bits[ticks/16].
    bit            m_act  [NI];
    int            m_cnt  [NI];
    int            m_nb   [NI];
    int            m_total[NI];
    bit            m_bits [NI][16];
    logic [NI-1:0] e_tx   = '1;
    logic [NI-1:0] e_busy = '0;
    logic [NI-1:0] e_done = '0;

    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            e_done[i] = 1'b0;
            if (!reset_n) begin
                m_act[i]  = 1'b0;
                e_tx[i]   = 1'b1;
                e_busy[i] = 1'b0;
            end else if (!m_act[i]) begin
                e_tx[i] = 1'b1;
                if (tx_start) begin
                    int ones;
                    ones = 0;
                    m_bits[i][0] = 1'b0;
                    for (int k = 0; k < CFG_DBIT[i]; k++) begin
                        m_bits[i][1+k] = din[k];
                        ones += int'(din[k]);
                    end
                    m_nb[i] = 1 + CFG_DBIT[i];
                    if (CFG_PE[i] != 0) begin
                        m_bits[i][m_nb[i]] = ((ones % 2) == 1) ^ (CFG_PO[i] != 0);
                        m_nb[i]++;
                    end
                    m_total[i] = 16 * m_nb[i] + CFG_SB[i];
                    m_cnt[i]   = 0;
                    m_act[i]   = 1'b1;
                    e_tx[i]    = 1'b0;
                    e_busy[i]  = 1'b1;
                end
            end else if (s_tick) begin
                m_cnt[i]++;
                if (m_cnt[i] == m_total[i]) begin
                    m_act[i]  = 1'b0;
                    e_done[i] = 1'b1;
                    e_busy[i] = 1'b0;
                    e_tx[i]   = 1'b1;
                end else if (m_cnt[i] / 16 < m_nb[i]) begin
                    e_tx[i] = m_bits[i][m_cnt[i] / 16];
                end else begin
                    e_tx[i] = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NI; i++) begin
                chk($sformatf("tx[%0d]", i), 8'(o_tx[i]), 8'(e_tx[i]));
                chk($sformatf("busy[%0d]", i), 8'(o_busy[i]), 8'(e_busy[i]));
                chk($sformatf("done[%0d]", i), 8'(o_done[i]), 8'(e_done[i]));
            end
        end
    end

    int done8_cnt = 0;
    always @(negedge clk) if (o_done[0] === 1'b1) done8_cnt++;

    // Mid-bit line samples, indexed by bit position within the frame
    logic c_tx [NI][16];
    logic c_busy7 [16];

    task automatic tick_gap(input int gmin, input int gmax);
        int gap;
        gap = $urandom_range(gmax, gmin);
        repeat (gap - 1) @(negedge clk);
        s_tick = 1'b1;
        @(negedge clk);
        s_tick = 1'b0;
    endtask

    task automatic send(input logic [7:0] v, input int gmin, input int gmax,
                        input int ntick, input bit tk0,
                        input int poke_at, input int rst_at);
        int cnt;
        @(negedge clk);
        tx_start = 1'b1;
        din      = v;
        s_tick   = tk0;
        @(negedge clk);
        tx_start = 1'b0;
        s_tick   = 1'b0;
        din      = 8'($urandom);
        for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < NI; i++) c_tx[i][j] = 1'bx;
            c_busy7[j] = 1'bx;
        end
        cnt = 0;
        while (cnt < ntick) begin
            tick_gap(gmin, gmax);
            cnt++;
            if (cnt % 16 == 8) begin
                for (int i = 0; i < NI; i++) c_tx[i][cnt/16] = o_tx[i];
                c_busy7[cnt/16] = o_busy[3];
            end
            if (cnt == poke_at) begin
                tx_start = 1'b1;
                din      = 8'h3C;
                @(negedge clk);
                tx_start = 1'b0;
                din      = 8'($urandom);
            end
            if (cnt == rst_at) begin
                reset_n = 1'b0;
                @(negedge clk);
                reset_n = 1'b1;
                chk("rst tx", 8'(o_tx), 8'h1F);
                chk("rst busy", 8'(o_busy), 8'h00);
                chk("rst done", 8'(o_done), 8'h00);
            end
        end
    endtask

    function automatic logic [7:0] gather(input int inst, input int nbits);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < nbits; k++) r[k] = c_tx[inst][1+k];
        return r;
    endfunction

    typedef struct {
        logic [7:0] din;
        logic [7:0] exp7;
        logic [7:0] exp5;
        logic       pe;
        logic       po;
        int         gmin;
        int         gmax;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int d0;
        int bound;
        vecs[0] = '{8'hA5, 8'h25, 8'h05, 1'b0, 1'b1, 4, 4};
        vecs[1] = '{8'h07, 8'h07, 8'h07, 1'b1, 1'b0, 1, 9};
        vecs[2] = '{8'hFF, 8'h7F, 8'h1F, 1'b0, 1'b1, 1, 9};
        vecs[3] = '{8'h81, 8'h01, 8'h01, 1'b0, 1'b1, 1, 9};
        vecs[4] = '{8'h3C, 8'h3C, 8'h1C, 1'b0, 1'b1, 2, 6};
        vecs[5] = '{8'h01, 8'h01, 8'h01, 1'b1, 1'b0, 1, 3};
        vecs[6] = '{8'hE9, 8'h69, 8'h09, 1'b1, 1'b0, 1, 9};

        repeat (3) @(negedge clk);
        chk("reset tx", 8'(o_tx), 8'h1F);
        chk("reset busy", 8'(o_busy), 8'h00);
        chk("reset done", 8'(o_done), 8'h00);
        reset_n = 1'b1;
        chk_en  = 1'b1;

        // Idle ticks alone must not start a frame
        repeat (20) tick_gap(1, 3);
        chk("idle busy", 8'(o_busy), 8'h00);

        foreach (vecs[v]) begin
            d0 = done8_cnt;
            send(vecs[v].din, vecs[v].gmin, vecs[v].gmax, 180, 1'b0, -1, -1);
            chk("u8 start", 8'(c_tx[0][0]), 8'h00);
            chk("u8 data", gather(0, 8), vecs[v].din);
            chk("u8 stop", 8'(c_tx[0][9]), 8'h01);
            chk("pe parity", 8'(c_tx[1][9]), 8'(vecs[v].pe));
            chk("po parity", 8'(c_tx[2][9]), 8'(vecs[v].po));
            chk("u7 data", gather(3, 7), vecs[v].exp7);
            chk("u7 stop", 8'(c_tx[3][8]), 8'h01);
            chk("u7 long stop busy", 8'(c_busy7[9]), 8'h01);
            chk("u5 data", gather(4, 5), vecs[v].exp5);
            chk("u5 stop", 8'(c_tx[4][6]), 8'h01);
            chk("u8 done count", 8'(done8_cnt - d0), 8'h01);
        end

        // s_tick coincident with acceptance is not counted
        send(8'hC3, 1, 9, 180, 1'b1, -1, -1);
        chk("tk0 data", gather(0, 8), 8'hC3);

        // tx_start mid-frame is ignored
        send(8'hA5, 4, 4, 180, 1'b0, 40, -1);
        chk("busy-ignore data", gather(0, 8), 8'hA5);
        chk("busy-ignore parity", 8'(c_tx[1][9]), 8'h00);

        // Reset during data bit 3 aborts with no done pulse
        d0 = done8_cnt;
        send(8'hA5, 2, 5, 180, 1'b0, -1, 70);
        chk("abort no done", 8'(done8_cnt - d0), 8'h00);
        send(8'h81, 1, 9, 180, 1'b0, -1, -1);
        chk("post-reset data", gather(0, 8), 8'h81);
        chk("post-reset parity", 8'(c_tx[1][9]), 8'h00);

        // Back-to-back: tx_start held across the done cycle
        @(negedge clk);
        tx_start = 1'b1;
        din      = 8'hA5;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (150) tick_gap(2, 2);
        tx_start = 1'b1;
        din      = 8'h55;
        bound    = 0;
        while (o_done[0] !== 1'b1 && bound < 2000) begin
            s_tick = bound[0];
            @(negedge clk);
            bound++;
        end
        s_tick = 1'b0;
        chk("b2b done seen", 8'(bound < 2000), 8'h01);
        chk("b2b done busy", 8'(o_busy[0]), 8'h00);
        @(negedge clk);
        tx_start = 1'b0;
        chk("b2b start tx", 8'(o_tx[0]), 8'h00);
        chk("b2b start busy", 8'(o_busy[0]), 8'h01);
        chk("b2b done width", 8'(o_done[0]), 8'h00);
        repeat (200) tick_gap(1, 9);
        chk("final idle", 8'(o_busy), 8'h00);

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

endmodule
